cp0_unit: RTL and testbench

- Coprocessor-0 for the 5-stage MIPS pipeline: the exception/interrupt responder that the fetch stage consumes.
- Sits beside the memory stage and holds SR, Cause, EPC and PRId.
- Samples each cycle the exception code and PC of the instruction in M, plus the 6 hardware interrupt lines.
- Drives IntReq, which redirects fetch to the handler, and EPC, which fetch uses on eret. Serves mfc0 reads and mtc0 writes.

---
 rtl/cp0_pkg.sv | 81 ++++++++
 rtl/cp0_timer.sv | 42 ++++
 rtl/cp0_unit.sv | 136 +++++++++++++
 tb/tb_cp0_unit.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 slice.
// Register indices, SR/Cause field positions, exception codes, the handler
// address and small helpers that pack the register images for mfc0 reads.
package cp0_pkg;

    // CP0 register indices as seen by mfc0/mtc0
    localparam logic [4:0] REG_COUNT   = 5'd9;
    localparam logic [4:0] REG_COMPARE = 5'd11;
    localparam logic [4:0] REG_SR      = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;
    localparam logic [4:0] REG_PRID    = 5'd15;

    // SR field positions
    localparam int SR_IE_BIT  = 0;
    localparam int SR_EXL_BIT = 1;
    localparam int SR_IM_LSB  = 10;
    localparam int SR_IM_MSB  = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LSB = 2;
    localparam int CAUSE_EXC_MSB = 6;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_IP_MSB  = 15;
    localparam int CAUSE_BD_BIT  = 31;

    // Exception codes
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Fetch redirects here whenever IntReq is high
    localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

    localparam int NUM_HWINT = 6;

    // Only the implemented SR bits are stored
    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    // Only the implemented Cause bits are stored
    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    // SR image as returned by mfc0; unimplemented bits read 0
    function automatic logic [31:0] sr_to_word(sr_t s);
        logic [31:0] w;
        w = '0;
        w[SR_IM_MSB:SR_IM_LSB] = s.im;
        w[SR_EXL_BIT]          = s.exl;
        w[SR_IE_BIT]           = s.ie;
        return w;
    endfunction

    // Cause image as returned by mfc0; unimplemented bits read 0
    function automatic logic [31:0] cause_to_word(cause_t c);
        logic [31:0] w;
        w = '0;
        w[CAUSE_BD_BIT]                = c.bd;
        w[CAUSE_IP_MSB:CAUSE_IP_LSB]   = c.ip;
        w[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = c.exc_code;
        return w;
    endfunction

    // Return address for a faulting instruction: word-aligned PC, backed up
    // onto the branch when the instruction sits in a delay slot (mod 2^32)
    function automatic logic [31:0] exc_epc(logic [31:0] pc, logic in_delay_slot);
        logic [31:0] aligned;
        aligned = pc & ~32'h3;
        return in_delay_slot ? (aligned - 32'd4) : aligned;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: free-running Count, Compare and the sticky timer-pending flag.
// Only instantiated when CP0_COUNT_EN is defined.
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic        pend_reg;
    logic        match;

    // The match is visible in the same cycle Count reaches Compare
    assign match      = (count_reg == compare_reg);
    assign timer_pend = pend_reg | match;
    assign count      = count_reg;
    assign compare    = compare_reg;

    // Count runs every cycle unless overwritten; a Compare write acknowledges the timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            compare_reg <= '0;
            pend_reg    <= 1'b0;
        end else begin
            count_reg <= count_we ? wdata : (count_reg + 32'd1);
            if (compare_we) begin
                compare_reg <= wdata;
                pend_reg    <= 1'b0;
            end else if (match) begin
                pend_reg <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor 0 for the 5-stage MIPS pipeline.
// Holds SR, Cause, EPC and PRId, raises IntReq combinationally for the
// instruction in M and serves mfc0/mtc0.
// Optional build macro CP0_COUNT_EN adds Count/Compare and a timer interrupt
// on HWInt[5].
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4B52,
    parameter logic [31:0] EPC_RESET  = 32'h0000_3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PCM,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    sr_t         sr_reg, sr_next;
    cause_t      cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;

    logic [5:0]  hwint_eff;
    logic [5:0]  irq_masked;
    logic        int_pend;
    logic        exc_pend;
    logic        mtc0_ok;

`ifdef CP0_COUNT_EN
    logic [31:0] count_val;
    logic [31:0] compare_val;
    logic        timer_pend;

    cp0_timer u_timer (
        .clk        (Clk),
        .rst        (Reset),
        .count_we   (mtc0_ok && (A2 == REG_COUNT)),
        .compare_we (mtc0_ok && (A2 == REG_COMPARE)),
        .wdata      (DIn),
        .count      (count_val),
        .compare    (compare_val),
        .timer_pend (timer_pend)
    );

    // Timer shares the top hardware interrupt line
    assign hwint_eff = {HWInt[5] | timer_pend, HWInt[4:0]};
`else
    assign hwint_eff = HWInt;
`endif

    // Per-line interrupt masking by SR.IM
    genvar gi;
    generate
        for (gi = 0; gi < NUM_HWINT; gi++) begin : g_irq_mask
            assign irq_masked[gi] = hwint_eff[gi] & sr_reg.im[gi];
        end
    endgenerate

    // EXL masks both sources, so a handler is never re-entered
    assign int_pend = (|irq_masked) & sr_reg.ie & ~sr_reg.exl;
    assign exc_pend = (ExcCodeIn != EXC_INT) & ~sr_reg.exl;
    assign IntReq   = int_pend | exc_pend;

    // A taken exception cancels the M instruction, so its mtc0/eret must not land
    assign mtc0_ok  = WE & ~IntReq;

    assign EPC = epc_reg;

    // Next-state: capture on IntReq, otherwise mtc0 then eret (eret clears EXL last)
    always_comb begin
        sr_next       = sr_reg;
        cause_next    = cause_reg;
        epc_next      = epc_reg;
        cause_next.ip = hwint_eff;
        if (IntReq) begin
            sr_next.exl         = 1'b1;
            cause_next.exc_code = int_pend ? EXC_INT : ExcCodeIn;
            cause_next.bd       = BDIn;
            epc_next            = exc_epc(PCM, BDIn);
        end else begin
            if (WE) begin
                case (A2)
                    REG_SR: begin
                        sr_next.im  = DIn[SR_IM_MSB:SR_IM_LSB];
                        sr_next.exl = DIn[SR_EXL_BIT];
                        sr_next.ie  = DIn[SR_IE_BIT];
                    end
                    REG_EPC: epc_next = DIn & ~32'h3;
                    default: ;
                endcase
            end
            if (EXLClr) begin
                sr_next.exl = 1'b0;
            end
        end
    end

    // Architectural register state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sr_reg    <= '0;
            cause_reg <= '0;
            epc_reg   <= EPC_RESET;
        end else begin
            sr_reg    <= sr_next;
            cause_reg <= cause_next;
            epc_reg   <= epc_next;
        end
    end

    // mfc0 read port: pre-edge state, no bypass of a same-cycle mtc0
    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = sr_to_word(sr_reg);
            REG_CAUSE: DOut = cause_to_word(cause_reg);
            REG_EPC:   DOut = epc_reg;
            REG_PRID:  DOut = PRID_VALUE;
`ifdef CP0_COUNT_EN
            REG_COUNT:   DOut = count_val;
            REG_COMPARE: DOut = compare_val;
`endif
            default:   DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed scoreboard bench for cp0_unit.
// Stimulus queues the expected IntReq/DOut/EPC for each cycle it drives; a
// monitor on the falling edge pops and compares against the DUT.
// Build with CP0_COUNT_EN defined to also exercise the timer.
module tb_cp0_unit;

    logic        Clk;
    logic        Reset;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PCM;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    localparam int SEL_INTREQ = 0;
    localparam int SEL_DOUT   = 1;
    localparam int SEL_EPC    = 2;
    localparam int TIMEOUT_NS = 100000;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   txn_no;

    cp0_unit dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .A1        (A1),
        .A2        (A2),
        .DIn       (DIn),
        .WE        (WE),
        .PCM       (PCM),
        .BDIn      (BDIn),
        .ExcCodeIn (ExcCodeIn),
        .HWInt     (HWInt),
        .EXLClr    (EXLClr),
        .IntReq    (IntReq),
        .EPC       (EPC),
        .DOut      (DOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Watchdog: a run that never finishes is reported as a failure
    initial begin
        #(TIMEOUT_NS);
        errors++;
        $display("FAIL timeout: expired wait after %0d ns", TIMEOUT_NS);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Monitor: compare everything queued for this cycle on the falling edge
    exp_t        cur;
    logic [31:0] act;
    always @(negedge Clk) begin
        while (sb.size() != 0) begin
            cur = sb.pop_front();
            case (cur.sel)
                SEL_INTREQ: act = {31'd0, IntReq};
                SEL_DOUT:   act = DOut;
                default:    act = EPC;
            endcase
            checks++;
            if (act !== cur.val) begin
                errors++;
                $display("FAIL %s: got %h, expected %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic idle();
        A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; WE = 1'b0; PCM = 32'd0;
        BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
    endtask

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        sb.push_back(e);
    endtask

    // Immediate comparison, independent of the clock
    task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp_v);
        end
    endtask

    task automatic mtc0(input logic [4:0] idx, input logic [31:0] data);
        WE = 1'b1; A2 = idx; DIn = data;
    endtask

    // Close the current cycle: one line per transaction, then advance past the edge
    task automatic step(input string label);
        txn_no++;
        $display("txn %0d: %s", txn_no, label);
        @(posedge Clk);
        #1;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        txn_no = 0;
        Reset  = 1'b1;
        idle();
        repeat (2) @(posedge Clk);
        #1;

        // Reset state
        A1 = 5'd15;
        expect_val("reset_prid", SEL_DOUT, 32'h0000_4B52);
        expect_val("reset_intreq", SEL_INTREQ, 32'd0);
        expect_val("reset_epc", SEL_EPC, 32'h0000_3000);
        step("reset held, read PRId");
        Reset = 1'b0;

        // Park Compare far away so the timer stays quiet in a CP0_COUNT_EN build
        A1 = 5'd12;
        mtc0(5'd11, 32'hFFFF_FFFF);
        expect_val("reset_sr", SEL_DOUT, 32'd0);
        step("mtc0 Compare");

        A1 = 5'd11;
`ifdef CP0_COUNT_EN
        expect_val("compare_rd", SEL_DOUT, 32'hFFFF_FFFF);
`else
        expect_val("idx11_rd", SEL_DOUT, 32'd0);
`endif
        step("read idx 11");

        A1 = 5'd13;
        expect_val("reset_cause", SEL_DOUT, 32'd0);
        mtc0(5'd9, 32'h0000_1234);
        step("read Cause, mtc0 Count");

        A1 = 5'd9;
`ifdef CP0_COUNT_EN
        expect_val("count_rd", SEL_DOUT, 32'h0000_1234);
`else
        expect_val("idx9_rd", SEL_DOUT, 32'd0);
`endif
        step("read idx 9");

        // Exception capture
        ExcCodeIn = 5'd12; PCM = 32'h0000_3008;
        expect_val("ov_intreq", SEL_INTREQ, 32'd1);
        expect_val("ov_epc_pre", SEL_EPC, 32'h0000_3000);
        step("overflow in M");

        A1 = 5'd14;
        expect_val("ov_epc_rd", SEL_DOUT, 32'h0000_3008);
        expect_val("ov_epc", SEL_EPC, 32'h0000_3008);
        expect_val("ov_intreq_after", SEL_INTREQ, 32'd0);
        step("read EPC");

        A1 = 5'd13;
        expect_val("ov_cause", SEL_DOUT, 32'h0000_0030);
        step("read Cause");

        A1 = 5'd12; ExcCodeIn = 5'd4;
        expect_val("ov_sr_exl", SEL_DOUT, 32'h0000_0002);
        expect_val("nested_masked", SEL_INTREQ, 32'd0);
        step("AdEL while EXL");

        // eret, then enable IM[10]/IE
        EXLClr = 1'b1; A1 = 5'd12;
        expect_val("eret_intreq", SEL_INTREQ, 32'd0);
        expect_val("eret_sr_pre", SEL_DOUT, 32'h0000_0002);
        step("eret");

        A1 = 5'd12;
        mtc0(5'd12, 32'h0000_0401);
        expect_val("sr_after_eret", SEL_DOUT, 32'd0);
        expect_val("sr_wr_intreq", SEL_INTREQ, 32'd0);
        step("mtc0 SR=0x401");

        // Delay slot plus interrupt-over-exception priority
        HWInt = 6'b000001; ExcCodeIn = 5'd10; PCM = 32'h0000_3020; BDIn = 1'b1; A1 = 5'd12;
        expect_val("prio_intreq", SEL_INTREQ, 32'd1);
        expect_val("prio_sr_pre", SEL_DOUT, 32'h0000_0401);
        step("int + RI in delay slot");

        HWInt = 6'b000001; A1 = 5'd13;
        expect_val("prio_cause", SEL_DOUT, 32'h8000_0400);
        expect_val("prio_epc", SEL_EPC, 32'h0000_301C);
        expect_val("prio_masked", SEL_INTREQ, 32'd0);
        step("read Cause");

        HWInt = 6'b000001; A1 = 5'd12;
        expect_val("prio_sr", SEL_DOUT, 32'h0000_0403);
        step("read SR");

        // eret with an interrupt held pending
        HWInt = 6'b000001; EXLClr = 1'b1;
        expect_val("eret2_intreq", SEL_INTREQ, 32'd0);
        step("eret with HWInt[0] high");

        HWInt = 6'b000001; PCM = 32'h0000_3030; A1 = 5'd12;
        expect_val("eret2_rise", SEL_INTREQ, 32'd1);
        expect_val("eret2_sr", SEL_DOUT, 32'h0000_0401);
        step("interrupt after eret");

        A1 = 5'd13;
        expect_val("irq_intreq", SEL_INTREQ, 32'd0);
        expect_val("irq_epc", SEL_EPC, 32'h0000_3030);
        expect_val("irq_cause", SEL_DOUT, 32'h0000_0400);
        step("read Cause");

        // mtc0 / mfc0 on EPC and ignored writes
        mtc0(5'd14, 32'h0000_3047);
        expect_val("epc_wr_intreq", SEL_INTREQ, 32'd0);
        step("mtc0 EPC=0x3047");

        A1 = 5'd14;
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("epc_wr_rd", SEL_DOUT, 32'h0000_3044);
        expect_val("epc_wr", SEL_EPC, 32'h0000_3044);
        step("read EPC, mtc0 Cause");

        A1 = 5'd13;
        mtc0(5'd15, 32'h0000_0000);
        expect_val("cause_wr_ignored", SEL_DOUT, 32'd0);
        step("read Cause, mtc0 PRId");

        A1 = 5'd15;
        expect_val("prid_wr_ignored", SEL_DOUT, 32'h0000_4B52);
        step("read PRId");

        EXLClr = 1'b1;
        step("eret");

        // Squash: mtc0 EPC in the same cycle as an exception
        mtc0(5'd14, 32'h0000_3047);
        ExcCodeIn = 5'd5; PCM = 32'h0000_3050;
        expect_val("squash_intreq", SEL_INTREQ, 32'd1);
        step("AdES with mtc0 EPC");

        A1 = 5'd14;
        expect_val("squash_epc_rd", SEL_DOUT, 32'h0000_3050);
        expect_val("squash_epc", SEL_EPC, 32'h0000_3050);
        step("read EPC");

        A1 = 5'd13;
        expect_val("squash_cause", SEL_DOUT, 32'h0000_0014);
        step("read Cause");

        // mtc0 SR together with eret: data first, then EXL cleared
        mtc0(5'd12, 32'hFFFF_FFFF);
        EXLClr = 1'b1;
        expect_val("sr_eret_intreq", SEL_INTREQ, 32'd0);
        step("mtc0 SR + eret");

        A1 = 5'd12;
        expect_val("sr_eret", SEL_DOUT, 32'h0000_FC01);
        expect_val("sr_eret_idle", SEL_INTREQ, 32'd0);
        step("read SR");

        // EPC wrap-around in a delay slot with a misaligned PC
        ExcCodeIn = 5'd4; PCM = 32'h0000_0002; BDIn = 1'b1;
        expect_val("wrap_intreq", SEL_INTREQ, 32'd1);
        step("AdEL at PC=2 in delay slot");

        A1 = 5'd13;
        expect_val("wrap_epc", SEL_EPC, 32'hFFFF_FFFC);
        expect_val("wrap_cause", SEL_DOUT, 32'h8000_0010);
        step("read Cause");

        mtc0(5'd14, 32'h0000_3010);
        step("mtc0 EPC=0x3010");

        A1 = 5'd12;
        expect_val("pre_reset_epc", SEL_EPC, 32'h0000_3010);
        expect_val("pre_reset_sr", SEL_DOUT, 32'h0000_FC03);
        step("read SR");

        // Asynchronous reset mid-operation, checked before any clock edge
        Reset = 1'b1; A1 = 5'd12;
        #1;
        check_now("async_now_intreq", {31'd0, IntReq}, 32'd0);
        check_now("async_now_epc", EPC, 32'h0000_3000);
        check_now("async_now_sr", DOut, 32'd0);
        A1 = 5'd13;
        #1;
        check_now("async_now_cause", DOut, 32'd0);
        A1 = 5'd12;
        expect_val("async_sr", SEL_DOUT, 32'd0);
        expect_val("async_epc", SEL_EPC, 32'h0000_3000);
        expect_val("async_intreq", SEL_INTREQ, 32'd0);
        step("async reset");

        A1 = 5'd13;
        expect_val("async_cause", SEL_DOUT, 32'd0);
        step("reset held, read Cause");
        Reset = 1'b0;

`ifdef CP0_COUNT_EN
        // Timer: Count=0, Compare=5, enable IM[15]/IE
        mtc0(5'd9, 32'd0);
        step("mtc0 Count=0");

        A1 = 5'd9;
        mtc0(5'd11, 32'd5);
        expect_val("tmr_count0", SEL_DOUT, 32'd0);
        step("mtc0 Compare=5");

        A1 = 5'd9;
        mtc0(5'd12, 32'h0000_8001);
        expect_val("tmr_count1", SEL_DOUT, 32'd1);
        expect_val("tmr_c1_intreq", SEL_INTREQ, 32'd0);
        step("mtc0 SR=0x8001");

        for (int i = 2; i < 5; i++) begin
            expect_val("tmr_early", SEL_INTREQ, 32'd0);
            step("timer counting");
        end

        A1 = 5'd9;
        expect_val("tmr_count5", SEL_DOUT, 32'd5);
        expect_val("tmr_fire", SEL_INTREQ, 32'd1);
        step("Count==Compare");

        A1 = 5'd13;
        mtc0(5'd11, 32'd5);
        expect_val("tmr_cause", SEL_DOUT, 32'h0000_8000);
        expect_val("tmr_exl_mask", SEL_INTREQ, 32'd0);
        step("mtc0 Compare=5 again");

        EXLClr = 1'b1;
        expect_val("tmr_eret", SEL_INTREQ, 32'd0);
        step("eret");

        A1 = 5'd11;
        expect_val("tmr_cleared", SEL_INTREQ, 32'd0);
        expect_val("tmr_compare", SEL_DOUT, 32'd5);
        step("timer acknowledged");
`else
        A1 = 5'd12;
        expect_val("post_reset_sr", SEL_DOUT, 32'd0);
        expect_val("post_reset_intreq", SEL_INTREQ, 32'd0);
        step("read SR after reset");
`endif

        @(negedge Clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
